// File: rtl/tick_multiplier_pkg.sv
// Shared types and default sizing for the tick rate multiplier.
package tick_multiplier_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCK    = 2'd2
    } state_e;

    localparam int N_DEF  = 100;
    localparam int CW_DEF = 7;
    localparam int PW_DEF = 24;

endpackage

// File: rtl/tick_multiplier_if.sv
// Tick input and sub-tick/status outputs of the rate multiplier.
interface tick_multiplier_if #(
    parameter int CW = tick_multiplier_pkg::CW_DEF,
    parameter int PW = tick_multiplier_pkg::PW_DEF
);
    logic          TICK_IN;
    logic          OUT;
    logic [CW-1:0] SubCount;
    logic [PW-1:0] Period;
    logic          LOCKED;

    modport master (output TICK_IN, input OUT, SubCount, Period, LOCKED);
    modport slave  (input TICK_IN, output OUT, SubCount, Period, LOCKED);
endinterface

// File: rtl/tick_multiplier_dda.sv
// Accumulator that spreads N sub-ticks across one period; SubCount saturates at N-1.
module tick_dda
    import tick_multiplier_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int CW = CW_DEF,
    parameter int PW = PW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_i,
    input  logic          step_i,
    input  logic [PW-1:0] period_i,
    output logic          pulse_o,
    output logic [CW-1:0] sub_count_o
);
    // One extra bit: acc < Period and N <= Period, so acc+N < 2*Period.
    logic [PW:0]   acc_q, acc_d, sum;
    logic [CW-1:0] sub_q, sub_d;
    logic          hit, sat;

    assign sum     = acc_q + (PW+1)'(N);
    assign hit     = sum >= {1'b0, period_i};
    assign sat     = sub_q == CW'(N-1);
    assign pulse_o = step_i && hit && !sat;

    always_comb begin
        acc_d = acc_q;
        sub_d = sub_q;
        if (load_i) begin
            acc_d = '0;
            sub_d = '0;
        end else if (step_i) begin
            acc_d = hit ? sum - {1'b0, period_i} : sum;
            if (pulse_o) sub_d = sub_q + 1'b1;
        end
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            sub_q <= '0;
        end else begin
            acc_q <= acc_d;
            sub_q <= sub_d;
        end
    end

    assign sub_count_o = sub_q;
endmodule

// File: rtl/tick_multiplier.sv
// Measures the input tick period and regenerates N evenly spaced sub-ticks per period.
module tick_multiplier
    import tick_multiplier_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int CW = CW_DEF,
    parameter int PW = PW_DEF
) (
    input  logic CLK,
    input  logic CLEAR,
    tick_multiplier_if.slave bus
);
    localparam logic [PW-1:0] CNT_MAX = '1;

    state_e        state_q, state_d;
    logic [PW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] period_q, period_d;
    logic          out_q, out_d;
    logic [PW:0]   meas;
    logic          tick, valid, timeout, load, step, pulse;

    assign tick    = bus.TICK_IN;
    assign meas    = {1'b0, cnt_q} + 1'b1;
    assign valid   = meas >= (PW+1)'(N);
    // Timeout fires on the edge where cnt would reach all-ones; a coincident tick wins.
    assign timeout = !tick && (cnt_q == CNT_MAX - 1'b1);
    assign load    = tick && valid && (state_q != IDLE);
    assign step    = (state_q == LOCK) && !tick && !timeout;
    assign cnt_d   = tick ? '0 : (cnt_q == CNT_MAX ? cnt_q : cnt_q + 1'b1);

    always_ff @(negedge CLK or negedge CLEAR) begin
        if (!CLEAR) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:          if (tick) state_d = ACQUIRE;
            ACQUIRE, LOCK: begin
                if (tick)         state_d = valid ? LOCK : ACQUIRE;
                else if (timeout) state_d = IDLE;
            end
            default:       state_d = IDLE;
        endcase
    end

    always_comb begin
        out_d    = load | pulse;
        period_d = period_q;
        if (load)                             period_d = meas[PW-1:0];
        else if (timeout && state_q != IDLE)  period_d = '0;
    end

    always_ff @(negedge CLK or negedge CLEAR) begin
        if (!CLEAR) begin
            cnt_q    <= '0;
            period_q <= '0;
            out_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            period_q <= period_d;
            out_q    <= out_d;
        end
    end

    tick_dda #(.N(N), .CW(CW), .PW(PW)) u_dda (
        .clk         (CLK),
        .rst_n       (CLEAR),
        .load_i      (load),
        .step_i      (step),
        .period_i    (period_q),
        .pulse_o     (pulse),
        .sub_count_o (bus.SubCount)
    );

    assign bus.OUT    = out_q;
    assign bus.Period = period_q;
    assign bus.LOCKED = (state_q == LOCK);
endmodule

// File: doc/tick_multiplier.md
# tick_multiplier

Rate multiplier that is the inverse of the divide-by-N event counter: it measures the period of a slow input tick in CLK cycles and emits exactly N evenly spaced single-cycle sub-ticks per measured period, phase-aligned to each input tick. It sits downstream of slow event sources (divided ticks, external strobes) to regenerate a fine-grained timebase. Sub-tick spacing uses an accumulator (DDA), not a divider.

## Interface
- N, 100: sub-ticks generated per input tick period.
- CW, 7: width of SubCount; must hold N-1.
- PW, 24: width of period counter and Period output.
- CLK  in  1  clock; all state updates on the falling edge.
- CLEAR  in  1  asynchronous, active-low reset.
- TICK_IN  in  1  synchronous, single-cycle input tick.
- OUT  out  1  registered single-cycle sub-tick pulse.
- SubCount  out  CW  index of the last emitted sub-tick, 0..N-1.
- Period  out  PW  last valid measured period, in CLK cycles.
- LOCKED  out  1  high while generating sub-ticks.

## Operation
- States: IDLE (no tick seen), ACQUIRE (one tick seen, measuring), LOCK (generating).
- Period counter cnt: cleared to 0 on each TICK_IN cycle; +1 on every other cycle. Measured period is P = cnt+1 at the tick.
- IDLE: TICK_IN goes to ACQUIRE and clears cnt. OUT stays 0.
- ACQUIRE and LOCK, on TICK_IN:
  - If P >= N: Period <= P, go to LOCK, OUT=1, SubCount=0, acc=0.
  - If P < N: go to ACQUIRE, LOCKED=0, no OUT. Period is unchanged.
- LOCK, on a non-tick cycle:
  - s = acc+N.
  - If s >= Period and SubCount < N-1: OUT=1, SubCount+1, acc = s-Period.
  - If s >= Period and SubCount = N-1: OUT=0 and acc = s-Period. This suppresses any pulse beyond N per period.
  - Otherwise: acc = s.
- Stable period: exactly N pulses per period, including the tick-aligned one. Gaps are floor/ceil of Period/N.
- Period change: the new Period takes effect at the tick that measured it. acc and SubCount resync and no pulse is carried over.
- Period longer than expected (late tick): sub-ticks stop at SubCount=N-1 and wait for the next tick.
- Timeout: if cnt reaches 2^PW-1 without a tick, go to IDLE with LOCKED=0 and Period=0.
- Widths: acc is PW+1 bits (acc < Period and N <= Period, so s < 2·Period). Comparisons are unsigned. cnt saturates and never wraps.
- LOCKED = (state == LOCK).

## Timing
- CLEAR low: immediately state=IDLE and OUT=0, SubCount=0, Period=0, LOCKED=0, cnt=0, acc=0. Held while low.
- First valid edge after CLEAR rises behaves as normal operation.
- Latency: TICK_IN sampled high at edge k gives OUT=1 during cycle k+1.
- Sub-tick j>0 (stable period P) appears during cycle k+1+m, where m is the smallest value with floor(m·N/P) = j.
- TICK_IN coinciding with a would-be sub-tick: the tick rule wins, so OUT=1 and SubCount=0.
- TICK_IN coinciding with timeout: the tick wins.
- TICK_IN held high for several cycles: each high cycle is a tick, with P=1 < N, so the block drops to ACQUIRE.
- LOCKED rises in the same cycle as the first tick-aligned OUT. It falls in the cycle after an invalid or timed-out period is detected.

## Structure
- Shared package holds:
  - state enum IDLE/ACQUIRE/LOCK (2-bit);
  - default constants N=100, CW=7, PW=24.
- Sub-module tick_dda (the acc/compare/subtract/SubCount-saturation datapath) with inputs load, step, Period and outputs pulse, SubCount.
- Top level holds the period counter, the FSM and the output registers.

## Test plan
- TICK_IN every 200 cycles, 3 periods → Period=200 and LOCKED=1 after the 2nd tick. OUT every 2 cycles, 100 pulses per period, SubCount 0..99, tick-aligned pulse at SubCount=0.
- TICK_IN every 250 cycles → exactly 100 pulses per period, gaps only 2 or 3, final SubCount=99.
- Locked at 200, then one interval of 50 → LOCKED=0, no OUT, Period stays 200. Next interval of 300 → relock with Period=300.
- Locked at 200, next tick 300 cycles late → pulses stop at SubCount=99 until the tick arrives, then resync with Period=300.
- PW=10, one tick then silence → IDLE and Period=0 after 1023 cycles. Tick at cycle 1023 → tick wins over timeout.
- Locked at 200, CLEAR low mid-period for 3 cycles → all outputs 0 immediately. Two ticks after release are needed to relock.
